// File: rtl/cmplx_mult_pipe.sv
// rtl/cmplx_mult_pipe.sv - pipelined signed complex multiplier with conjugate, rounding and saturation
module cmplx_mult_pipe #(
  parameter int DATA_W = 18,
  parameter int OUT_W  = 18,
  parameter int SHIFT  = 17
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic              conj_i,
  input  logic [DATA_W-1:0] data_a_i_i,
  input  logic [DATA_W-1:0] data_a_q_i,
  input  logic [DATA_W-1:0] data_b_i_i,
  input  logic [DATA_W-1:0] data_b_q_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [OUT_W-1:0]  data_i_o,
  output logic [OUT_W-1:0]  data_q_o,
  output logic              sat_o,
  output logic              ovf_o,
  input  logic              ovf_clr_i
);

  localparam int PW  = 2 * DATA_W;
  localparam int P   = 2 * DATA_W + 1;
  localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;

  // Rounding and clamp constants are held at P+1 bits so the half-LSB add never wraps.
  localparam logic [P:0] ONE   = {{P{1'b0}}, 1'b1};
  localparam logic [P:0] RND_U = (SHIFT > 0) ? (ONE << RSH) : {(P+1){1'b0}};
  localparam logic [P:0] MAX_U = (ONE << (OUT_W - 1)) - ONE;
  localparam logic [P:0] MIN_U = ~MAX_U;

  logic adv;

  logic                     s1_valid, s1_conj;
  logic signed [DATA_W-1:0] s1_ar, s1_ai, s1_br, s1_bi;

  logic                 s2_valid, s2_conj;
  logic signed [PW-1:0] s2_rr, s2_ii, s2_ri, s2_ir;

  logic signed [PW-1:0] ar_x, ai_x, br_x, bi_x;
  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;

  logic signed [P:0] rr_x, ii_x, ri_x, ir_x;
  logic signed [P:0] re_full, im_full, re_scl, im_scl;
  logic              re_hi, re_lo, im_hi, im_lo;
  logic [OUT_W-1:0]  re_out, im_out;

  assign adv       = !m_valid_o || m_ready_i;
  assign s_ready_o = adv;

  // Operands widened to the product width so the multiply cannot lose the -min*-min case.
  always_comb begin
    ar_x = {{DATA_W{s1_ar[DATA_W-1]}}, s1_ar};
    ai_x = {{DATA_W{s1_ai[DATA_W-1]}}, s1_ai};
    br_x = {{DATA_W{s1_br[DATA_W-1]}}, s1_br};
    bi_x = {{DATA_W{s1_bi[DATA_W-1]}}, s1_bi};
    p_rr = ar_x * br_x;
    p_ii = ai_x * bi_x;
    p_ri = ar_x * bi_x;
    p_ir = ai_x * br_x;
  end

  always_comb begin
    rr_x = {{2{s2_rr[PW-1]}}, s2_rr};
    ii_x = {{2{s2_ii[PW-1]}}, s2_ii};
    ri_x = {{2{s2_ri[PW-1]}}, s2_ri};
    ir_x = {{2{s2_ir[PW-1]}}, s2_ir};

    if (s2_conj) begin
      re_full = rr_x + ii_x;
      im_full = ir_x - ri_x;
    end else begin
      re_full = rr_x - ii_x;
      im_full = ri_x + ir_x;
    end

    re_scl = (re_full + $signed(RND_U)) >>> SHIFT;
    im_scl = (im_full + $signed(RND_U)) >>> SHIFT;

    re_hi = re_scl > $signed(MAX_U);
    re_lo = re_scl < $signed(MIN_U);
    im_hi = im_scl > $signed(MAX_U);
    im_lo = im_scl < $signed(MIN_U);

    re_out = re_hi ? MAX_U[OUT_W-1:0] : (re_lo ? MIN_U[OUT_W-1:0] : re_scl[OUT_W-1:0]);
    im_out = im_hi ? MAX_U[OUT_W-1:0] : (im_lo ? MIN_U[OUT_W-1:0] : im_scl[OUT_W-1:0]);
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      s1_valid  <= 1'b0;
      s1_conj   <= 1'b0;
      s1_ar     <= '0;
      s1_ai     <= '0;
      s1_br     <= '0;
      s1_bi     <= '0;
      s2_valid  <= 1'b0;
      s2_conj   <= 1'b0;
      s2_rr     <= '0;
      s2_ii     <= '0;
      s2_ri     <= '0;
      s2_ir     <= '0;
      m_valid_o <= 1'b0;
      data_i_o  <= '0;
      data_q_o  <= '0;
      sat_o     <= 1'b0;
    end else if (adv) begin
      s1_valid  <= s_valid_i;
      s1_conj   <= conj_i;
      s1_ar     <= data_a_i_i;
      s1_ai     <= data_a_q_i;
      s1_br     <= data_b_i_i;
      s1_bi     <= data_b_q_i;
      s2_valid  <= s1_valid;
      s2_conj   <= s1_conj;
      s2_rr     <= p_rr;
      s2_ii     <= p_ii;
      s2_ri     <= p_ri;
      s2_ir     <= p_ir;
      m_valid_o <= s2_valid;
      data_i_o  <= re_out;
      data_q_o  <= im_out;
      sat_o     <= s2_valid & (re_hi | re_lo | im_hi | im_lo);
    end
  end

  // A saturated beat that transfers this cycle outranks a concurrent clear.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      ovf_o <= 1'b0;
    end else if (m_valid_o && m_ready_i && sat_o) begin
      ovf_o <= 1'b1;
    end else if (ovf_clr_i) begin
      ovf_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cmplx_mult_pipe.sv
// tb/tb_cmplx_mult_pipe.sv - randomized and directed bench for cmplx_mult_pipe against a behavioural model
module tb_cmplx_mult_pipe;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  logic arst_i;

  logic        s_valid, conj, m_ready, ovf_clr;
  logic [17:0] a_i, a_q, b_i, b_q;
  logic        s_ready, m_valid, sat, ovf;
  logic [17:0] d_i, d_q;

  logic        sw_valid, sw_conj, sw_ready;
  logic [17:0] sw_ai, sw_aq, sw_bi, sw_bq;
  logic        s8_ready, m8_valid, sat8, ovf8;
  logic [7:0]  d8_i, d8_q;
  logic        s37_ready, m37_valid, sat37, ovf37;
  logic [36:0] d37_i, d37_q;

  cmplx_mult_pipe u_dut (
    .clk_i(clk_i), .arst_i(arst_i), .s_valid_i(s_valid), .s_ready_o(s_ready), .conj_i(conj),
    .data_a_i_i(a_i), .data_a_q_i(a_q), .data_b_i_i(b_i), .data_b_q_i(b_q),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .data_i_o(d_i), .data_q_o(d_q),
    .sat_o(sat), .ovf_o(ovf), .ovf_clr_i(ovf_clr)
  );

  cmplx_mult_pipe #(.DATA_W(8), .OUT_W(8), .SHIFT(7)) u_dut8 (
    .clk_i(clk_i), .arst_i(arst_i), .s_valid_i(sw_valid), .s_ready_o(s8_ready), .conj_i(sw_conj),
    .data_a_i_i(sw_ai[7:0]), .data_a_q_i(sw_aq[7:0]), .data_b_i_i(sw_bi[7:0]), .data_b_q_i(sw_bq[7:0]),
    .m_valid_o(m8_valid), .m_ready_i(sw_ready), .data_i_o(d8_i), .data_q_o(d8_q),
    .sat_o(sat8), .ovf_o(ovf8), .ovf_clr_i(1'b0)
  );

  cmplx_mult_pipe #(.DATA_W(18), .OUT_W(37), .SHIFT(0)) u_dut37 (
    .clk_i(clk_i), .arst_i(arst_i), .s_valid_i(sw_valid), .s_ready_o(s37_ready), .conj_i(sw_conj),
    .data_a_i_i(sw_ai), .data_a_q_i(sw_aq), .data_b_i_i(sw_bi), .data_b_q_i(sw_bq),
    .m_valid_o(m37_valid), .m_ready_i(sw_ready), .data_i_o(d37_i), .data_q_o(d37_q),
    .sat_o(sat37), .ovf_o(ovf37), .ovf_clr_i(1'b0)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  typedef struct {
    longint i;
    longint q;
    bit     s;
  } beat_t;

  beat_t exp_q[$];
  beat_t exp8_q[$];
  beat_t exp37_q[$];

  // Exact product, half-up rounding by floor((x + half) / 2^sh), then clamp to ow bits.
  function automatic longint scale(input longint x, input int ow, input int sh, output bit s);
    longint r, mx, mn;
    r = x;
    if (sh > 0) r = (x + (longint'(1) << (sh - 1))) >>> sh;
    mx = (longint'(1) << (ow - 1)) - 1;
    mn = -mx - 1;
    s = 1'b0;
    if (r > mx) begin r = mx; s = 1'b1; end
    else if (r < mn) begin r = mn; s = 1'b1; end
    return r;
  endfunction

  function automatic beat_t model(input int ow, input int sh, input longint ar, input longint ai,
                                  input longint br, input longint bi, input bit cj);
    beat_t  b;
    longint re, im;
    bit     s1, s2;
    if (cj) begin
      re = ar * br + ai * bi;
      im = ai * br - ar * bi;
    end else begin
      re = ar * br - ai * bi;
      im = ar * bi + ai * br;
    end
    b.i = scale(re, ow, sh, s1);
    b.q = scale(im, ow, sh, s2);
    b.s = s1 | s2;
    return b;
  endfunction

  logic        held;
  logic [17:0] h_i, h_q;
  logic        h_s;

  always @(negedge clk_i) begin : mon_main
    beat_t b;
    if (arst_i) begin
      exp_q.delete();
      held = 1'b0;
    end else begin
      check("s_ready", longint'(s_ready), longint'(!(m_valid && !m_ready)));
      if (held) begin
        check("hold_i", longint'(d_i), longint'(h_i));
        check("hold_q", longint'(d_q), longint'(h_q));
        check("hold_sat", longint'(sat), longint'(h_s));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check("extra_beat", 1, 0);
        else begin
          b = exp_q.pop_front();
          check("out_i", longint'($signed(d_i)), b.i);
          check("out_q", longint'($signed(d_q)), b.q);
          check("out_sat", longint'(sat), longint'(b.s));
        end
      end
      if (s_valid && s_ready)
        exp_q.push_back(model(18, 17, longint'($signed(a_i)), longint'($signed(a_q)),
                              longint'($signed(b_i)), longint'($signed(b_q)), conj));
      held = m_valid && !m_ready;
      h_i = d_i;
      h_q = d_q;
      h_s = sat;
    end
  end

  always @(negedge clk_i) begin : mon_sweep
    beat_t b;
    if (arst_i) begin
      exp8_q.delete();
      exp37_q.delete();
    end else begin
      if (m8_valid && sw_ready) begin
        if (exp8_q.size() == 0) check("extra_beat8", 1, 0);
        else begin
          b = exp8_q.pop_front();
          check("out8_i", longint'($signed(d8_i)), b.i);
          check("out8_q", longint'($signed(d8_q)), b.q);
          check("out8_sat", longint'(sat8), longint'(b.s));
        end
      end
      if (m37_valid && sw_ready) begin
        if (exp37_q.size() == 0) check("extra_beat37", 1, 0);
        else begin
          b = exp37_q.pop_front();
          check("out37_i", longint'($signed(d37_i)), b.i);
          check("out37_q", longint'($signed(d37_q)), b.q);
          check("out37_nosat", longint'(sat37), 0);
        end
      end
      if (sw_valid && s8_ready)
        exp8_q.push_back(model(8, 7, longint'($signed(sw_ai[7:0])), longint'($signed(sw_aq[7:0])),
                               longint'($signed(sw_bi[7:0])), longint'($signed(sw_bq[7:0])), sw_conj));
      if (sw_valid && s37_ready)
        exp37_q.push_back(model(37, 0, longint'($signed(sw_ai)), longint'($signed(sw_aq)),
                                longint'($signed(sw_bi)), longint'($signed(sw_bq)), sw_conj));
    end
  end

  function automatic logic [17:0] rnd18();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0:       return r[17:0];
      1:       return {{8{r[9]}}, r[9:0]};
      2:       return r[0] ? 18'h20000 : 18'h1FFFF;
      default: return {{2{r[15]}}, r[15:0]};
    endcase
  endfunction

  task automatic align();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [17:0] ai, input logic [17:0] aq, input logic [17:0] bi,
                      input logic [17:0] bq, input bit cj);
    s_valid = 1'b1;
    conj = cj;
    a_i = ai; a_q = aq; b_i = bi; b_q = bq;
    align();
  endtask

  task automatic expect_out(input string tag, input longint ei, input longint eq, input bit es);
    bit found;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk_i);
      if (m_valid && m_ready) begin
        found = 1'b1;
        check({tag, "_i"}, longint'($signed(d_i)), ei);
        check({tag, "_q"}, longint'($signed(d_q)), eq);
        check({tag, "_sat"}, longint'(sat), longint'(es));
      end
    end
    if (!found) check({tag, "_timeout"}, 0, 1);
  endtask

  initial begin : stim
    bit acc;
    int sw_sent;
    int cyc;

    arst_i = 1'b1;
    s_valid = 1'b0; conj = 1'b0; m_ready = 1'b1; ovf_clr = 1'b0;
    a_i = '0; a_q = '0; b_i = '0; b_q = '0;
    sw_valid = 1'b0; sw_conj = 1'b0; sw_ready = 1'b1;
    sw_ai = '0; sw_aq = '0; sw_bi = '0; sw_bq = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_m_valid", longint'(m_valid), 0);
    check("rst_data_i", longint'(d_i), 0);
    check("rst_sat", longint'(sat), 0);
    check("rst_ovf", longint'(ovf), 0);
    #2 arst_i = 1'b0;
    align();

    for (int k = 0; k < 5; k++) send(rnd18(), rnd18(), rnd18(), rnd18(), 1'b0);
    arst_i = 1'b1;
    s_valid = 1'b0;
    #1;
    check("midrst_m_valid", longint'(m_valid), 0);
    check("midrst_data_i", longint'(d_i), 0);
    check("midrst_data_q", longint'(d_q), 0);
    check("midrst_sat", longint'(sat), 0);
    @(negedge clk_i);
    #2 arst_i = 1'b0;
    repeat (4) @(negedge clk_i);
    check("no_ghost", longint'(m_valid), 0);
    align();

    send(18'd65536, 18'd0, 18'd65536, 18'd0, 1'b0);
    s_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk_i);
      check($sformatf("latency_c%0d", k), longint'(m_valid), longint'(k == 3));
    end
    check("lat_data_i", longint'($signed(d_i)), 32768);
    check("lat_data_q", longint'($signed(d_q)), 0);
    check("lat_sat", longint'(sat), 0);
    align();

    send(18'd0, 18'd65536, 18'd0, 18'd65536, 1'b0);
    send(18'd0, 18'd65536, 18'd0, 18'd65536, 1'b1);
    s_valid = 1'b0;
    expect_out("conj0", -32768, 0, 1'b0);
    expect_out("conj1", 32768, 0, 1'b0);
    align();

    send(18'd1, 18'd0, 18'd65536, 18'd0, 1'b0);
    send(18'd1, 18'd0, 18'd65535, 18'd0, 1'b0);
    send(18'h3FFFF, 18'd0, 18'd65536, 18'd0, 1'b0);
    s_valid = 1'b0;
    expect_out("rnd_half", 1, 0, 1'b0);
    expect_out("rnd_below", 0, 0, 1'b0);
    expect_out("rnd_neg", 0, 0, 1'b0);
    align();

    send(18'h20000, 18'd0, 18'h20000, 18'd0, 1'b0);
    s_valid = 1'b0;
    expect_out("sat", 131071, 0, 1'b1);
    @(negedge clk_i);
    check("ovf_set", longint'(ovf), 1);
    repeat (3) @(negedge clk_i);
    check("ovf_hold", longint'(ovf), 1);
    align();
    ovf_clr = 1'b1;
    align();
    ovf_clr = 1'b0;
    check("ovf_clr", longint'(ovf), 0);
    send(18'h20000, 18'd0, 18'h20000, 18'd0, 1'b0);
    s_valid = 1'b0;
    expect_out("sat2", 131071, 0, 1'b1);
    check("ovf_pre", longint'(ovf), 0);
    ovf_clr = 1'b1;
    align();
    ovf_clr = 1'b0;
    check("ovf_set_wins", longint'(ovf), 1);

    acc = 1'b1;
    for (int k = 0; k < 80; k++) begin
      if (acc || !s_valid) begin
        s_valid = ($urandom_range(0, 3) != 0);
        conj = $urandom_range(0, 1);
        a_i = rnd18(); a_q = rnd18(); b_i = rnd18(); b_q = rnd18();
      end
      m_ready = $urandom_range(0, 1);
      @(negedge clk_i);
      acc = s_valid && s_ready;
      align();
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    repeat (8) @(negedge clk_i);
    check("drain_main", exp_q.size(), 0);
    align();

    sw_sent = 0;
    cyc = 0;
    while (sw_sent < 1000 && cyc < 6000) begin
      sw_valid = ($urandom_range(0, 7) != 0);
      sw_conj = $urandom_range(0, 1);
      sw_ai = $urandom; sw_aq = $urandom; sw_bi = $urandom; sw_bq = $urandom;
      if ($urandom_range(0, 15) == 0) begin sw_ai = 18'h3FF80; sw_bi = 18'h3FF80; end
      sw_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk_i);
      if (sw_valid && s8_ready) sw_sent++;
      align();
      cyc++;
    end
    check("sweep_beats", longint'(sw_sent >= 1000), 1);
    sw_valid = 1'b0;
    sw_ready = 1'b1;
    repeat (8) @(negedge clk_i);
    check("drain8", exp8_q.size(), 0);
    check("drain37", exp37_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
